// File: rtl/keys_pkg.sv
// keys_pkg: constants shared by keys_debounce and spi_keys.
package keys_pkg;
    localparam int NUM_KEYS_DEFAULT = 61;
    localparam int CLK_HZ           = 12_000_000;
    localparam int TICK_DIV_DEFAULT = 12000;
    localparam int DB_COUNT_DEFAULT = 5;
endpackage

// File: rtl/keys_debounce_cell.sv
// keys_debounce_cell: one key's 2-flop synchronizer, debounce counter and state bit.
module keys_debounce_cell
    import keys_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_state,
    output logic o_flip
);
    localparam int CW = $clog2(DB_COUNT + 1);
    logic          r_s1;
    logic          r_s2;
    logic          r_state;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;
    assign w_diff  = r_s2 != r_state;
    assign w_done  = r_cnt == CW'(DB_COUNT - 1);
    // o_flip is combinational so the top can register the strobe on the same edge as the state.
    assign o_flip  = i_tick & w_diff & w_done;
    assign o_state = r_state;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (i_tick) begin
                r_cnt <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
                if (o_flip) r_state <= r_s2;
            end
        end
    end
endmodule

// File: rtl/keys_debounce.sv
// keys_debounce: per-key synchronize + debounce with shared prescaler tick and change strobe.
// KEYS_DEBOUNCE_ACTIVE_LOW_EN inverts raw inputs for pulled-up (low = pressed) switches.
module keys_debounce
    import keys_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic                clk_g_i,
    input  logic                rst_g_i,
    input  logic [NUM_KEYS-1:0] keys_raw_i_g,
    output logic [NUM_KEYS-1:0] keys_o_g,
    output logic                keys_chg_o_g
);
    localparam int DW = $clog2(TICK_DIV);
    logic [DW-1:0]       r_div;
    logic                r_chg;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_raw;
    logic [NUM_KEYS-1:0] w_flip;
`ifdef KEYS_DEBOUNCE_ACTIVE_LOW_EN
    assign w_raw = ~keys_raw_i_g;
`else
    assign w_raw = keys_raw_i_g;
`endif
    assign w_tick       = r_div == DW'(TICK_DIV - 1);
    assign keys_chg_o_g = r_chg;
    always_ff @(posedge clk_g_i) begin
        if (rst_g_i) begin
            r_div <= '0;
            r_chg <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            r_chg <= |w_flip;
        end
    end
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        keys_debounce_cell #(.DB_COUNT(DB_COUNT)) u_cell (
            .i_clk  (clk_g_i),
            .i_rst  (rst_g_i),
            .i_tick (w_tick),
            .i_raw  (w_raw[i]),
            .o_state(keys_o_g[i]),
            .o_flip (w_flip[i])
        );
    end
endmodule

// File: tb/tb_keys_debounce.sv
// tb_keys_debounce: directed test of keys_debounce against a tick/run-length model.
`timescale 1ns/1ps
module tb_keys_debounce;
    localparam int NK = 61;
    localparam int TD = 4;
    localparam int DB = 3;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] raw;
    logic [NK-1:0] keys;
    logic          chg;
    int            checks = 0;
    int            errors = 0;

    keys_debounce #(.NUM_KEYS(NK), .TICK_DIV(TD), .DB_COUNT(DB)) dut (
        .clk_g_i     (clk),
        .rst_g_i     (rst),
        .keys_raw_i_g(raw),
        .keys_o_g    (keys),
        .keys_chg_o_g(chg)
    );

    always #42 clk = ~clk;

    // Model: raw seen two edges late; every TD-th edge since reset is a tick;
    // a key flips once DB consecutive ticks disagree with its output.
    logic [NK-1:0] m_q[$];
    logic [NK-1:0] m_out;
    logic          m_chg;
    int            m_run[NK];
    int            m_n;
    bit            m_valid = 0;

    always @(posedge clk) begin
        logic [NK-1:0] s;
        if (rst) begin
            m_q.delete();
            m_q.push_back('0);
            m_q.push_back('0);
            m_out   = '0;
            m_chg   = 1'b0;
            m_n     = 0;
            m_valid = 1;
            foreach (m_run[k]) m_run[k] = 0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(raw);
            m_n++;
            m_chg = 1'b0;
            if (m_n % TD == 0) begin
                for (int k = 0; k < NK; k++) begin
                    if (s[k] == m_out[k]) m_run[k] = 0;
                    else begin
                        m_run[k]++;
                        if (m_run[k] == DB) begin
                            m_out[k] = s[k];
                            m_run[k] = 0;
                            m_chg    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (keys !== m_out) begin
                errors++;
                $display("FAIL model_keys: got %h expected %h at t=%0t", keys, m_out, $time);
            end
            checks++;
            if (chg !== m_chg) begin
                errors++;
                $display("FAIL model_chg: got %b expected %b at t=%0t", chg, m_chg, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_key(input int idx, input logic val, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (keys[idx] !== val && n < maxc);
    endtask

    int n;
    int pulses;
    int hi5;

    initial begin
        raw = NK'({$urandom(), $urandom()});
        @(negedge clk);
        chk("reset_keys_0", 64'(keys), 64'd0);
        chk("reset_chg_0", 64'(chg), 64'd0);
        raw = NK'({$urandom(), $urandom()});
        @(negedge clk);
        chk("reset_keys_1", 64'(keys), 64'd0);
        chk("reset_chg_1", 64'(chg), 64'd0);
        rst = 1'b0;
        raw = '0;
        // press key 0 right after reset: ticks at edges 4, 8, 12 -> accepted on edge 12
        raw[0] = 1'b1;
        wait_key(0, 1'b1, 20, n);
        chk("press_latency", 64'(n), 64'd12);
        chk("press_chg", 64'(chg), 64'd1);
        step();
        chk("press_chg_end", 64'(chg), 64'd0);
        // release one cycle after a tick edge: 3 ticks later is 11 edges
        raw[0] = 1'b0;
        wait_key(0, 1'b0, 20, n);
        chk("release_latency", 64'(n), 64'd11);
        chk("release_chg", 64'(chg), 64'd1);
        step();
        chk("release_chg_end", 64'(chg), 64'd0);
        // bounce: 8 cycles high covers at most 2 ticks
        pulses = 0;
        hi5    = 0;
        raw[5] = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i == 8) raw[5] = 1'b0;
            step();
            pulses += int'(chg);
            hi5    += int'(keys[5]);
        end
        chk("bounce_pulses", 64'(pulses), 64'd0);
        chk("bounce_key5", 64'(hi5), 64'd0);
        // simultaneous press of keys 0 and 60
        raw[0]  = 1'b1;
        raw[60] = 1'b1;
        wait_key(0, 1'b1, 20, n);
        chk("simul_latency", 64'(n), 64'd11);
        chk("simul_key60", 64'(keys[60]), 64'd1);
        chk("simul_chg", 64'(chg), 64'd1);
        step();
        chk("simul_chg_end", 64'(chg), 64'd0);
        raw[0]  = 1'b0;
        raw[60] = 1'b0;
        wait_key(0, 1'b0, 20, n);
        chk("simul_rel_latency", 64'(n), 64'd11);
        chk("simul_rel_key60", 64'(keys[60]), 64'd0);
        // reset mid-count: two disagreeing ticks, then reset clears the count
        raw[3] = 1'b1;
        repeat (9) step();
        chk("midcount_key3", 64'(keys[3]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_key(3, 1'b1, 20, n);
        chk("midcount_latency", 64'(n), 64'd12);
        chk("midcount_chg", 64'(chg), 64'd1);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
